// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin scheduler.
// Pick helpers operate on a fixed 32-bit vector; callers zero-extend narrower request sets.
package rr_sched_pkg;

   localparam int unsigned NREQ_MIN    = 2;
   localparam int unsigned NREQ_MAX    = 32;
   localparam int unsigned MAXHOLD_MIN = 1;
   localparam int unsigned MAXHOLD_MAX = 15;

   typedef enum logic {
      RR_IDLE = 1'b0,
      RR_OWN  = 1'b1
   } rr_state_t;

   typedef logic [NREQ_MAX-1:0] vec_t;

   typedef struct packed {
      logic       vld;
      logic [4:0] idx;
   } ff_t;

   // Bits strictly above the last winner; those requesters get first chance.
   function automatic vec_t rot_mask(input logic [4:0] ptr);
      vec_t m;
      m = '0;
      for (int unsigned i = 0; i < NREQ_MAX; i++) begin
         m[i] = (i > 32'(ptr));
      end
      return m;
   endfunction

   function automatic ff_t find_first1(input vec_t v);
      ff_t r;
      r = '0;
      for (int unsigned i = 0; i < NREQ_MAX; i++) begin
         if (v[i] && !r.vld) begin
            r.vld = 1'b1;
            r.idx = 5'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_sched_pick.sv
// Combinational rotating-priority pick: first request above ptr, else first request overall.
module rr_pick
   import rr_sched_pkg::*;
#(
   parameter int unsigned NREQ = 16,
   parameter int unsigned IDXW = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic            win_vld,
   output logic [IDXW-1:0] win_idx,
   output logic [NREQ-1:0] win_oh
);

   vec_t req_ext;
   ff_t  hi;
   ff_t  lo;
   ff_t  sel;

   always_comb begin
      req_ext = vec_t'(req);
      hi      = find_first1(req_ext & rot_mask(5'(ptr)));
      lo      = find_first1(req_ext);
      sel     = hi.vld ? hi : lo;
      win_vld = sel.vld;
      win_idx = IDXW'(sel.idx);
      win_oh  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         win_oh[i] = sel.vld && (sel.idx == 5'(i));
      end
   end

endmodule

// File: rtl/rr_sched.sv
// Round-robin scheduler with bounded-burst ownership and clock-gate enable
// for the shared resource.
module rr_sched
   import rr_sched_pkg::*;
#(
   parameter  int unsigned NREQ    = 16,
   parameter  int unsigned MAXHOLD = 4,
   localparam int unsigned IDXW    = $clog2(NREQ)
) (
   input  logic            ck,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] last,
   output logic [NREQ-1:0] gnt,
   output logic            gnt_vld,
   output logic [IDXW-1:0] gnt_idx,
   output logic            res_ck_en,
   output logic [15:0]     gnt_cnt
);

   localparam logic [3:0] HOLD_MAX = 4'(MAXHOLD);

   rr_state_t       state;
   logic [IDXW-1:0] ptr;
   logic [3:0]      hold;

   logic            win_vld;
   logic [IDXW-1:0] win_idx;
   logic [NREQ-1:0] win_oh;
   logic            rel;
   logic            start;

   // ptr always equals the owner while in OWN, so the same pick gives the owner lowest priority.
   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .win_vld (win_vld),
      .win_idx (win_idx),
      .win_oh  (win_oh)
   );

   always_comb begin
      rel   = (state == RR_OWN) && (!req[ptr] || last[ptr] || (hold == HOLD_MAX));
      start = ((state == RR_IDLE) || rel) && win_vld;
   end

   assign res_ck_en = (|req) | gnt_vld;

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RR_IDLE;
         ptr     <= IDXW'(NREQ - 1);
         hold    <= '0;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         gnt_idx <= '0;
         gnt_cnt <= '0;
      end else if (start) begin
         state   <= RR_OWN;
         ptr     <= win_idx;
         hold    <= 4'd1;
         gnt     <= win_oh;
         gnt_vld <= 1'b1;
         gnt_idx <= win_idx;
         gnt_cnt <= gnt_cnt + 16'd1;
      end else if (rel) begin
         state   <= RR_IDLE;
         hold    <= '0;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         gnt_idx <= '0;
      end else if (state == RR_OWN && hold != HOLD_MAX) begin
         hold <= hold + 4'd1;
      end
   end

   a_params : assert property (@(posedge ck)
      NREQ >= NREQ_MIN && NREQ <= NREQ_MAX && MAXHOLD >= MAXHOLD_MIN && MAXHOLD <= MAXHOLD_MAX);
   a_onehot : assert property (@(posedge ck) disable iff (!rst_n) $onehot0(gnt));
   a_vld    : assert property (@(posedge ck) disable iff (!rst_n) gnt_vld == (|gnt));
   a_hold   : assert property (@(posedge ck) disable iff (!rst_n) hold <= HOLD_MAX);
   a_stable : assert property (@(posedge ck) disable iff (!rst_n)
      (state == RR_OWN && !rel) |=> $stable(gnt));

endmodule

// File: tb/tb_rr_sched.sv
// Randomized and directed checks of rr_sched against a circular-search reference model.
`timescale 1ns/1ps
module tb_rr_sched;

   localparam int unsigned NREQ    = 16;
   localparam int unsigned MAXHOLD = 4;

   logic        ck = 1'b0;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] last;
   logic [15:0] gnt;
   logic        gnt_vld;
   logic [3:0]  gnt_idx;
   logic        res_ck_en;
   logic [15:0] gnt_cnt;

   int errors = 0;
   int checks = 0;

   int m_own;
   int m_ptr;
   int m_hold;
   int m_cnt;

   always #5 ck = ~ck;

   rr_sched #(
      .NREQ    (NREQ),
      .MAXHOLD (MAXHOLD)
   ) dut (
      .ck        (ck),
      .rst_n     (rst_n),
      .req       (req),
      .last      (last),
      .gnt       (gnt),
      .gnt_vld   (gnt_vld),
      .gnt_idx   (gnt_idx),
      .res_ck_en (res_ck_en),
      .gnt_cnt   (gnt_cnt)
   );

   task automatic model_reset();
      m_own  = -1;
      m_ptr  = NREQ - 1;
      m_hold = 0;
      m_cnt  = 0;
   endtask

   // Owner keeps the grant unless it finishes, abandons or uses up its burst;
   // then the next requester is found by walking circularly from the last winner.
   task automatic model_step(input logic [15:0] r, input logic [15:0] l);
      bit rel;
      int w;
      rel = (m_own < 0) || !r[m_own] || l[m_own] || (m_hold == MAXHOLD);
      if (!rel) begin
         m_hold++;
      end else begin
         w = -1;
         for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && r[idx]) w = idx;
         end
         if (w >= 0) begin
            m_own  = w;
            m_ptr  = w;
            m_hold = 1;
            m_cnt  = (m_cnt + 1) % 65536;
         end else begin
            m_own  = -1;
            m_hold = 0;
         end
      end
   endtask

   function automatic logic [15:0] m_gnt();
      return (m_own < 0) ? 16'h0000 : (16'h0001 << m_own);
   endfunction

   task automatic drive(input logic [15:0] r, input logic [15:0] l);
      req  = r;
      last = l;
      @(posedge ck);
      model_step(r, l);
      @(negedge ck);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req   = '0;
      last  = '0;
      model_reset();
      @(negedge ck);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (gnt !== 16'h0000 || gnt_vld !== 1'b0 || gnt_idx !== 4'd0) begin
         errors++;
         $display("FAIL reset_outputs gnt=%h vld=%b idx=%0d expected 0/0/0", gnt, gnt_vld, gnt_idx);
      end
      checks++;
      if (gnt_cnt !== 16'h0000 || res_ck_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_cnt_en cnt=%h en=%b expected 0000/0", gnt_cnt, res_ck_en);
      end
   endtask

   task automatic test_single();
      apply_reset();
      drive(16'h0001, 16'h0000);
      checks++;
      if (gnt !== 16'h0001 || gnt_cnt !== 16'd1 || gnt_vld !== 1'b1) begin
         errors++;
         $display("FAIL single_grant gnt=%h cnt=%0d vld=%b expected 0001/1/1", gnt, gnt_cnt, gnt_vld);
      end
      drive(16'h0001, 16'h0000);
      checks++;
      if (gnt !== 16'h0001 || gnt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL single_hold gnt=%h cnt=%0d expected 0001/1", gnt, gnt_cnt);
      end
      drive(16'h0000, 16'h0001);
      checks++;
      if (gnt_vld !== 1'b0 || gnt !== 16'h0000 || gnt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL single_drop vld=%b gnt=%h cnt=%0d expected 0/0000/1", gnt_vld, gnt, gnt_cnt);
      end
   endtask

   task automatic test_rotation();
      logic [15:0] exp_seq [4];
      exp_seq = '{16'h0001, 16'h0004, 16'h8000, 16'h0001};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive(16'h8005, 16'hFFFF);
         checks++;
         if (gnt !== exp_seq[i] || gnt_vld !== 1'b1 || gnt_cnt !== 16'(i + 1)) begin
            errors++;
            $display("FAIL rotation step=%0d gnt=%h vld=%b cnt=%0d expected %h/1/%0d",
                     i, gnt, gnt_vld, gnt_cnt, exp_seq[i], i + 1);
         end
      end
   endtask

   task automatic test_preempt();
      logic [15:0] exp_g;
      apply_reset();
      for (int c = 0; c < 12; c++) begin
         drive(16'h0003, 16'h0000);
         exp_g = (((c / 4) % 2) == 0) ? 16'h0001 : 16'h0002;
         checks++;
         if (gnt !== exp_g || gnt_cnt !== 16'(c / 4 + 1)) begin
            errors++;
            $display("FAIL preempt cycle=%0d gnt=%h cnt=%0d expected %h/%0d",
                     c, gnt, gnt_cnt, exp_g, c / 4 + 1);
         end
      end
   endtask

   task automatic test_abandon();
      apply_reset();
      drive(16'h0008, 16'h0000);
      drive(16'h0028, 16'h0000);
      drive(16'h0028, 16'h0020);
      checks++;
      if (gnt !== 16'h0008 || gnt_idx !== 4'd3 || gnt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL abandon_undisturbed gnt=%h idx=%0d cnt=%0d expected 0008/3/1", gnt, gnt_idx, gnt_cnt);
      end
      drive(16'h0020, 16'h0000);
      checks++;
      if (gnt !== 16'h0020 || gnt_idx !== 4'd5 || gnt_cnt !== 16'd2) begin
         errors++;
         $display("FAIL abandon_switch gnt=%h idx=%0d cnt=%0d expected 0020/5/2", gnt, gnt_idx, gnt_cnt);
      end
      for (int i = 0; i < 3; i++) drive(16'h0020, 16'h0000);
      checks++;
      if (gnt !== 16'h0020 || gnt_cnt !== 16'd2) begin
         errors++;
         $display("FAIL abandon_hold_restart gnt=%h cnt=%0d expected 0020/2", gnt, gnt_cnt);
      end
      drive(16'h0020, 16'h0000);
      checks++;
      if (gnt !== 16'h0020 || gnt_cnt !== 16'd3) begin
         errors++;
         $display("FAIL abandon_burst_end gnt=%h cnt=%0d expected 0020/3", gnt, gnt_cnt);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      drive(16'h0010, 16'h0000);
      checks++;
      if (gnt !== 16'h0010) begin
         errors++;
         $display("FAIL async_pre gnt=%h expected 0010", gnt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (gnt !== 16'h0000 || gnt_vld !== 1'b0 || gnt_idx !== 4'd0 || gnt_cnt !== 16'd0) begin
         errors++;
         $display("FAIL async_clear gnt=%h vld=%b idx=%0d cnt=%0d expected 0000/0/0/0",
                  gnt, gnt_vld, gnt_idx, gnt_cnt);
      end
      model_reset();
      req = 16'h0011;
      #1;
      checks++;
      if (res_ck_en !== 1'b1) begin
         errors++;
         $display("FAIL async_en_in_reset en=%b expected 1", res_ck_en);
      end
      @(negedge ck);
      rst_n = 1'b1;
      drive(16'h0011, 16'h0000);
      checks++;
      if (gnt !== 16'h0001 || gnt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL async_first_grant gnt=%h cnt=%0d expected 0001/1", gnt, gnt_cnt);
      end
   endtask

   task automatic test_clock_gate();
      apply_reset();
      req = 16'h0000;
      #1;
      checks++;
      if (res_ck_en !== 1'b0) begin
         errors++;
         $display("FAIL cg_idle en=%b expected 0", res_ck_en);
      end
      req = 16'h0004;
      #1;
      checks++;
      if (res_ck_en !== 1'b1 || gnt_vld !== 1'b0) begin
         errors++;
         $display("FAIL cg_early en=%b vld=%b expected 1/0", res_ck_en, gnt_vld);
      end
      drive(16'h0004, 16'h0000);
      checks++;
      if (gnt !== 16'h0004 || res_ck_en !== 1'b1) begin
         errors++;
         $display("FAIL cg_grant gnt=%h en=%b expected 0004/1", gnt, res_ck_en);
      end
      drive(16'h0000, 16'h0000);
      checks++;
      if (gnt_vld !== 1'b0 || res_ck_en !== 1'b0) begin
         errors++;
         $display("FAIL cg_off vld=%b en=%b expected 0/0", gnt_vld, res_ck_en);
      end
   endtask

   task automatic test_random();
      logic [15:0] r;
      logic [15:0] l;
      apply_reset();
      r = '0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) r = 16'($urandom) & 16'($urandom);
         l = 16'($urandom) & 16'($urandom) & 16'($urandom);
         drive(r, l);
         checks++;
         if (gnt !== m_gnt() || gnt_vld !== (m_own >= 0) || gnt_idx !== 4'((m_own < 0) ? 0 : m_own)) begin
            errors++;
            $display("FAIL random_grant cycle=%0d gnt=%h vld=%b idx=%0d expected %h/%b/%0d",
                     c, gnt, gnt_vld, gnt_idx, m_gnt(), (m_own >= 0), (m_own < 0) ? 0 : m_own);
         end
         checks++;
         if (gnt_cnt !== 16'(m_cnt) || res_ck_en !== ((|r) || (m_own >= 0))) begin
            errors++;
            $display("FAIL random_cnt_en cycle=%0d cnt=%0d en=%b expected %0d/%b",
                     c, gnt_cnt, res_ck_en, m_cnt, ((|r) || (m_own >= 0)));
         end
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 65535; i++) drive(16'h0001, 16'h0001);
      checks++;
      if (gnt_cnt !== 16'hFFFF || gnt !== 16'h0001) begin
         errors++;
         $display("FAIL wrap_max cnt=%h gnt=%h expected FFFF/0001", gnt_cnt, gnt);
      end
      drive(16'h0001, 16'h0001);
      checks++;
      if (gnt_cnt !== 16'h0000 || gnt !== 16'h0001) begin
         errors++;
         $display("FAIL wrap_zero cnt=%h gnt=%h expected 0000/0001", gnt_cnt, gnt);
      end
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog simulation time limit reached errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req   = '0;
      last  = '0;
      model_reset();
      @(negedge ck);
      test_reset();
      test_single();
      test_rotation();
      test_preempt();
      test_abandon();
      test_async_reset();
      test_clock_gate();
      test_random();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
